// File: rtl/alu_divmod_unit.sv
// alu_divmod_unit: iterative signed divider (restoring shift-subtract).
// One quotient bit per clock. Sign handling is done on magnitudes at accept
// and undone in the single FIN cycle.
//
// Handshake: a request is taken on a rising edge where state is IDLE,
// start=1 and (DIV_e|MOD_e)=1; busy is high from the cycle after accept
// until FIN completes; done is a one-cycle pulse in the first IDLE cycle,
// where result/div_by_zero become valid and then hold until the next FIN.
module alu_divmod_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             DIV_e,
    input  logic             MOD_e,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_dbz;
    logic             r_is_div;
    logic             r_sign_a;
    logic             r_sign_q;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_a_orig;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_b_mag;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_remd;
    logic [WIDTH-1:0] w_final;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    // Restoring step datapath and sign correction of the finished values.
    // The extra top bit of the difference acts as the borrow: clear means
    // the shifted remainder was >= |b|.
    always_comb begin
        w_shift = {r_rem, r_dvd[WIDTH-1]};
        w_diff  = w_shift - {2'b00, r_b_mag};
        w_ge    = ~w_diff[WIDTH+1];
        w_quot  = r_sign_q ? -r_dvd : r_dvd;
        w_remd  = r_sign_a ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        w_a_mag = a[WIDTH-1] ? -a : a;
        w_b_mag = b[WIDTH-1] ? -b : b;
        if (r_b_zero) begin
            w_final = r_is_div ? {WIDTH{1'b1}} : r_a_orig;
        end else begin
            w_final = r_is_div ? w_quot : w_remd;
        end
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_q <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_orig <= '0;
            r_dvd    <= '0;
            r_b_mag  <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (DIV_e || MOD_e)) begin
                        r_is_div <= DIV_e;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_b_zero <= (b == '0);
                        r_a_orig <= a;
                        r_dvd    <= w_a_mag;
                        r_b_mag  <= w_b_mag;
                        r_rem    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    if (w_ge) begin
                        r_rem <= w_diff[WIDTH:0];
                    end else begin
                        r_rem <= w_shift[WIDTH:0];
                    end
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_result <= w_final;
                    r_dbz    <= r_b_zero;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign div_by_zero = r_dbz;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_divmod_unit.sv
// Directed + light random bench for alu_divmod_unit (WIDTH=32).
// Expected {div_by_zero, result} values come from a behavioural signed
// division model and are queued at issue time, popped on done.
module tb_alu_divmod_unit;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         DIV_e = 1'b0;
    logic         MOD_e = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    logic [W:0]   exp_q[$];
    int           total = 0;
    int           bad = 0;

    alu_divmod_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .DIV_e(DIV_e),
        .MOD_e(MOD_e),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .div_by_zero(div_by_zero),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural reference: {div_by_zero, result}.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic d);
        logic signed [W-1:0] sx;
        logic signed [W-1:0] sy;
        logic [W-1:0] q;
        logic [W-1:0] r;
        sx = x;
        sy = y;
        if (y == '0) return {1'b1, d ? {W{1'b1}} : x};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x;
            r = '0;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
        return {1'b0, d ? q : r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a request for one edge (caller positions time before the edge),
    // then scramble operands while the unit is busy.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic d, input logic m, input bit push);
        if (push) exp_q.push_back(model(xa, xb, d));
        start = 1'b1;
        a = xa;
        b = xb;
        DIV_e = d;
        MOD_e = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        DIV_e = 1'b0;
        MOD_e = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Count edges from accept until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_done(input string tag, input int n);
        logic [W:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {(W+1){1'bx}};
        chk({tag, "_lat"}, 64'(n), 64'(LAT));
        chk({tag, "_res"}, 64'(result), 64'(e[W-1:0]));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e[W]));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic d, input logic m);
        int n;
        @(negedge clk);
        issue(xa, xb, d, m, 1'b1);
        chk({tag, "_busy_hi"}, 64'(busy), 64'd1);
        wait_done(n);
        check_done(tag, n);
    endtask

    initial begin
        int n;
        bit seen;

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);

        // basic and signed cases
        run_op("div_100_7", 32'd100, 32'd7, 1'b1, 1'b0);
        run_op("mod_100_7", 32'd100, 32'd7, 1'b0, 1'b1);
        run_op("div_m7_2", -32'sd7, 32'd2, 1'b1, 1'b0);
        run_op("mod_m7_2", -32'sd7, 32'd2, 1'b0, 1'b1);
        run_op("div_7_m2", 32'd7, -32'sd2, 1'b1, 1'b0);
        run_op("mod_7_m2", 32'd7, -32'sd2, 1'b0, 1'b1);
        run_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("mod_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // divide by zero, then reset mid-operation while the flag is set
        run_op("div_5_0", 32'd5, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        issue(32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_dbz", 64'(div_by_zero), 64'd0);
        chk("abort_state", 64'(dbg_state), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        run_op("mod_5_0", 32'd5, 32'd0, 1'b0, 1'b1);
        run_op("div_9_3", 32'd9, 32'd3, 1'b1, 1'b0);

        // back-to-back: next request issued in the done cycle
        run_op("b2b_first", 32'd1000, 32'd3, 1'b1, 1'b0);
        issue(32'd20, 32'd4, 1'b1, 1'b0, 1'b1);
        chk("b2b_accept", 64'(busy), 64'd1);
        wait_done(n);
        check_done("b2b_20_4", n);
        chk("b2b_spacing", 64'(n + 1), 64'd34);

        // start without enables is ignored
        @(negedge clk);
        issue(32'd50, 32'd5, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        chk("noen_busy", 64'(busy), 64'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("noen_quiet", 64'(seen), 64'd0);

        // both enables: DIV priority
        run_op("both_17_5", 32'd17, 32'd5, 1'b1, 1'b1);

        // reset and start on the same edge: request dropped
        @(negedge clk);
        rst = 1'b1;
        issue(32'd77, 32'd7, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        chk("rst_start_res", 64'(result), 64'd0);

        // random operations
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic rd;
            ra = $urandom;
            rb = W'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (i == 3) rb = '0;
            rd = 1'($urandom_range(0, 1));
            run_op("rand", ra, rb, rd, ~rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
